md_iter_core: RTL and testbench

Iterative multiply/divide engine that sits directly downstream of the E-stage HI/LO unit. The HI/LO unit issues `mult`/`multu`/`div`/`divu` operands to it and consumes the 64-bit result, then commits it to HI/LO. The core replaces single-cycle `*`, `/` and `%` with a one-bit-per-cycle shift-add multiplier and a restoring divider. Latency is fixed and data-independent, so the HI/LO busy window stays deterministic.

---
 rtl/md_pkg.sv | 17 +
 rtl/md_iter_core.sv | 152 +++++++++++++++
 tb/tb_md_iter_core.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_pkg.sv
// Op and state encodings shared by the multiply/divide core and the HI/LO issue decode.
package md_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10
  } md_state_e;
endpackage

// File: rtl/md_iter_core.sv
// Iterative shift-add multiplier / restoring divider; fixed WIDTH+2 cycle latency from Start to Done.
// No backpressure: Start is only accepted while idle, Abort cancels an in-flight op without a Done.
module md_iter_core
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  md_state_e          state_q, state_d;
  md_op_e             op_q, op_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   dvs_q, dvs_d;
  logic [WIDTH-1:0]   a_raw_q, a_raw_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               bzero_q, bzero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     sum, shl, trial;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_neg;
  logic [WIDTH-1:0]   quo, rem;

  assign a_neg = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg = ~op_i[0] & b_i[WIDTH-1];
  assign a_mag = a_neg ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_neg ? (~b_i + 1'b1) : b_i;

  // Multiply: acc = {partial product, remaining multiplier bits}, shifting right.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
  assign mul_step = {sum, acc_q[WIDTH-1:1]};

  // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
  assign shl      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign trial    = shl - {1'b0, dvs_q};
  assign div_step = trial[WIDTH] ? {shl[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  assign prod_neg = ~acc_q + 1'b1;
  assign quo      = acc_q[WIDTH-1:0];
  assign rem      = acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    a_raw_d   = a_raw_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (start_i && !abort_i) begin
          op_d      = md_op_e'(op_i);
          cnt_d     = '0;
          acc_d     = {{WIDTH{1'b0}}, op_i[1] ? a_mag : b_mag};
          dvs_d     = op_i[1] ? b_mag : a_mag;
          a_raw_d   = a_i;
          neg_res_d = a_neg ^ b_neg;
          neg_rem_d = a_neg;
          bzero_d   = (b_i == '0);
          state_d   = MD_CALC;
        end
      end
      MD_CALC: begin
        if (abort_i) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          acc_d = op_q[1] ? div_step : mul_step;
          if (cnt_q == LAST) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!abort_i) begin
          done_d = 1'b1;
          if (!op_q[1]) begin
            {hi_d, lo_d} = neg_res_q ? prod_neg : acc_q;
          end else if (bzero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            hi_d = neg_rem_q ? (~rem + 1'b1) : rem;
            lo_d = neg_res_q ? (~quo + 1'b1) : quo;
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= MD_IDLE;
      op_q      <= MD_MULT;
      cnt_q     <= '0;
      acc_q     <= '0;
      dvs_q     <= '0;
      a_raw_q   <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      a_raw_q   <= a_raw_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy_o = (state_q != MD_IDLE);
  assign done_o = done_q;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_md_iter_core.sv
// Randomized and directed checks of md_iter_core against an arithmetic reference model.
module tb_md_iter_core;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         start_i;
  logic [1:0]   op_i;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         abort_i;
  logic         busy_o;
  logic         done_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int total = 0;
  int bad   = 0;

  md_iter_core #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .abort_i(abort_i),
    .busy_o(busy_o), .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  // MIPS semantics: {HI,LO}; C-style truncating division, remainder follows dividend.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    if (op == MD_MULT) begin
      res = 64'(sa * sb);
    end else if (op == MD_MULTU) begin
      res = {32'b0, a} * {32'b0, b};
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFFFFFF};
    end else if (op == MD_DIV) begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end else begin
      res = {a % b, a / b};
    end
    return res;
  endfunction

  // Issues one op and waits for Done; scribbles on op/a/b while busy, optional Start poke at cycle 'poke'.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, output logic [63:0] res, output int lat, output int busy_cnt);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    lat = 1;
    busy_cnt = 0;
    while (!done_o && lat < 100) begin
      if (busy_o) busy_cnt++;
      op_i = 2'($urandom);
      a_i = $urandom;
      b_i = $urandom;
      start_i = (lat == poke);
      @(posedge clk_i); #1;
      lat++;
    end
    start_i = 1'b0;
    res = {hi_o, lo_o};
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done_o); end
    total++; if (hi_o !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", hi_o); end
    total++; if (lo_o !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", lo_o); end
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_directed();
    vec_t v[8];
    logic [63:0] res;
    int lat, bc;
    v[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
    v[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    v[2] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    v[3] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    v[4] = '{MD_DIVU,  32'd7,        32'd2,        32'd1,        32'd3};
    v[5] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    v[6] = '{MD_DIVU,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    v[7] = '{MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
    for (int i = 0; i < 8; i++) begin
      run_op(v[i].op, v[i].a, v[i].b, -1, res, lat, bc);
      total++; if (res !== {v[i].hi, v[i].lo}) begin bad++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, {v[i].hi, v[i].lo}); end
      total++; if (lat != 34) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=34", i, lat); end
      total++; if (bc != 33) begin bad++; $display("FAIL directed%0d_busy_cycles got=%0d exp=33", i, bc); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL directed%0d_busy_in_done got=%b exp=0", i, busy_o); end
      @(posedge clk_i); #1;
      total++; if (done_o !== 1'b0) begin bad++; $display("FAIL directed%0d_done_pulse got=%b exp=0", i, done_o); end
      total++; if ({hi_o, lo_o} !== res) begin bad++; $display("FAIL directed%0d_hold got=%h exp=%h", i, {hi_o, lo_o}, res); end
    end
  endtask

  task automatic test_random();
    logic [63:0] res, exp;
    logic [1:0] op;
    logic [31:0] a, b;
    int lat, bc;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom);
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) - 32'd4 : $urandom;
      exp = model(op, a, b);
      run_op(op, a, b, -1, res, lat, bc);
      total++; if (res !== exp) begin bad++; $display("FAIL random%0d op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
      total++; if (lat != 34) begin bad++; $display("FAIL random%0d_latency got=%0d exp=34", i, lat); end
    end
  endtask

  task automatic test_ignore_start();
    logic [63:0] res, exp;
    int lat, bc;
    exp = model(MD_DIV, 32'hFFFF1234, 32'd77);
    run_op(MD_DIV, 32'hFFFF1234, 32'd77, 5, res, lat, bc);
    total++; if (res !== exp) begin bad++; $display("FAIL ignore_start_result got=%h exp=%h", res, exp); end
    total++; if (lat != 34) begin bad++; $display("FAIL ignore_start_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_abort();
    logic [63:0] res, prev;
    int lat, bc, done_seen;
    int abort_at[2];
    run_op(MD_MULTU, 32'd3, 32'd4, -1, res, lat, bc);
    prev = res;
    abort_at[0] = 10;
    abort_at[1] = 33;
    for (int k = 0; k < 2; k++) begin
      op_i = MD_DIVU; a_i = 32'd1000; b_i = 32'd7; start_i = 1'b1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      for (int c = 1; c < abort_at[k]; c++) begin @(posedge clk_i); #1; end
      abort_i = 1'b1;
      @(posedge clk_i); #1;
      abort_i = 1'b0;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort%0d_busy got=%b exp=0", abort_at[k], busy_o); end
      done_seen = 0;
      for (int c = 0; c < 40; c++) begin
        if (done_o) done_seen++;
        @(posedge clk_i); #1;
      end
      total++; if (done_seen != 0) begin bad++; $display("FAIL abort%0d_no_done got=%0d exp=0", abort_at[k], done_seen); end
      total++; if ({hi_o, lo_o} !== prev) begin bad++; $display("FAIL abort%0d_hilo got=%h exp=%h", abort_at[k], {hi_o, lo_o}, prev); end
    end
    op_i = MD_MULT; a_i = 32'd9; b_i = 32'd9; start_i = 1'b1; abort_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0; abort_i = 1'b0;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL abort_priority_busy got=%b exp=0", busy_o); end
    @(posedge clk_i); #1;
  endtask

  task automatic test_back_to_back();
    logic [63:0] r1, r2, e1, e2;
    int l1, l2, bc;
    e1 = model(MD_MULT, 32'h12345678, 32'hFEDCBA98);
    e2 = model(MD_DIV, 32'h87654321, 32'h00001234);
    run_op(MD_MULT, 32'h12345678, 32'hFEDCBA98, -1, r1, l1, bc);
    run_op(MD_DIV, 32'h87654321, 32'h00001234, -1, r2, l2, bc);
    total++; if (r1 !== e1) begin bad++; $display("FAIL b2b_first got=%h exp=%h", r1, e1); end
    total++; if (r2 !== e2) begin bad++; $display("FAIL b2b_second got=%h exp=%h", r2, e2); end
    total++; if (l2 != 34) begin bad++; $display("FAIL b2b_second_latency got=%0d exp=34", l2); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat, bc;
    op_i = MD_DIV; a_i = 32'hFFFFF000; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    for (int c = 1; c < 20; c++) begin @(posedge clk_i); #1; end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy_o); end
    total++; if (done_o !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done_o); end
    total++; if ({hi_o, lo_o} !== 64'd0) begin bad++; $display("FAIL midreset_hilo got=%h exp=0", {hi_o, lo_o}); end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_op(MD_MULTU, 32'd3, 32'd4, -1, res, lat, bc);
    total++; if (res !== 64'd12) begin bad++; $display("FAIL after_reset_multu got=%h exp=%h", res, 64'd12); end
    total++; if (lat != 34) begin bad++; $display("FAIL after_reset_latency got=%0d exp=34", lat); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
